// File: rtl/aes_pkg.sv
// Shared constants and types for the iterative AES-128 encryption sequencer.
package aes_pkg;

  localparam int AES_WIDTH = 128;
  localparam int AES_NR    = 10;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_ROUND = 2'd1,
    FSM_DONE  = 2'd2
  } fsm_e;

  // Round constants for key expansion, indexed by round number 1..10.
  localparam logic [7:0] RCON [1:AES_NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

endpackage

// File: rtl/aes_rcon_rom.sv
// Combinational round-number to round-constant lookup; returns 0 when disabled
// or when the round number is outside 1..AES_NR.
module aes_rcon_rom
  import aes_pkg::*;
(
  input  logic [3:0] round,
  input  logic       enable,
  output logic [7:0] rcon
);

  logic [7:0] term [1:AES_NR];

  for (genvar gi = 1; gi <= AES_NR; gi++) begin : g_rcon
    assign term[gi] = (enable && (round == 4'(gi))) ? RCON[gi] : 8'h00;
  end

  // At most one term is non-zero, so an OR-reduction acts as the mux.
  always_comb begin
    rcon = 8'h00;
    for (int i = 1; i <= AES_NR; i++) begin
      rcon = rcon | term[i];
    end
  end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption sequencer: owns the state and round-key registers
// and steps an external round datapath and key-expansion step through rounds 1..NR.
module aes128_round_ctrl
  import aes_pkg::*;
#(
  parameter int WIDTH = AES_WIDTH,
  parameter int NR    = AES_NR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] key_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] state_o,
  output logic [WIDTH-1:0] rkey_o,
  output logic [7:0]       rcon_o,
  output logic             last_round_o,
  input  logic [WIDTH-1:0] round_data_i,
  input  logic [WIDTH-1:0] next_key_i
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  fsm_e             fsm_reg;
  logic [3:0]       round_reg;
  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] rkey_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             in_round;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg       <= FSM_IDLE;
      round_reg     <= 4'd0;
      state_reg     <= '0;
      rkey_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (fsm_reg)
        FSM_IDLE: begin
          if (in_valid_i && in_ready_reg) begin
            // Round-0 AddRoundKey is folded into the load.
            state_reg    <= data_i ^ key_i;
            rkey_reg     <= key_i;
            round_reg    <= 4'd1;
            in_ready_reg <= 1'b0;
            fsm_reg      <= FSM_ROUND;
          end
        end

        FSM_ROUND: begin
          state_reg <= round_data_i;
          rkey_reg  <= next_key_i;
          if (round_reg >= LAST_ROUND) begin
            round_reg     <= 4'd0;
            out_valid_reg <= 1'b1;
            fsm_reg       <= FSM_DONE;
          end else begin
            round_reg <= round_reg + 4'd1;
          end
        end

        FSM_DONE: begin
          // Ready rises only after the handshake, so accept happens a cycle later.
          if (out_valid_reg && out_ready_i) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            fsm_reg       <= FSM_IDLE;
          end
        end

        default: begin
          round_reg     <= 4'd0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          fsm_reg       <= FSM_IDLE;
        end
      endcase
    end
  end

  assign in_round = (fsm_reg == FSM_ROUND);

  aes_rcon_rom u_rcon_rom (
    .round  (round_reg),
    .enable (in_round),
    .rcon   (rcon_o)
  );

  assign last_round_o = in_round && (round_reg == LAST_ROUND);
  assign in_ready_o   = in_ready_reg;
  assign out_valid_o  = out_valid_reg;
  assign data_o       = state_reg;
  assign state_o      = state_reg;
  assign rkey_o       = rkey_reg;

`ifndef SYNTHESIS
  a_round_bound : assert property (@(posedge clk) disable iff (!rst_n)
    round_reg <= LAST_ROUND);

  a_ready_valid_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready_reg && out_valid_reg));

  a_output_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_reg && !out_ready_i) |=> (out_valid_reg && $stable(state_reg)));
`endif

endmodule

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
Iterative AES-128 encryption sequencer. It owns the 128-bit state register and round-key register and steps an external combinational round datapath (SubBytes, ShiftRows, MixColumn, AddRoundKey) and a key-expansion step through rounds 1..10. It presents a valid/ready stream interface on both plaintext input and ciphertext output. The block sits between the system bus shim and the round datapath.

Parameters:
WIDTH, 128, state/key/data width; only 128 is supported.
NR, 10, number of rounds; fixed for AES-128.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid_i  input  1  plaintext and key present
in_ready_o  output  1  controller can accept a block
data_i  input  WIDTH  plaintext
key_i  input  WIDTH  cipher key
out_valid_o  output  1  ciphertext valid
out_ready_i  input  1  downstream accepts ciphertext
data_o  output  WIDTH  ciphertext (state register)
state_o  output  WIDTH  current state to round datapath
rkey_o  output  WIDTH  current round key to key-expansion step
rcon_o  output  8  round constant for current round
last_round_o  output  1  1 in round NR; datapath bypasses MixColumn
round_data_i  input  WIDTH  datapath result for current round
next_key_i  input  WIDTH  key-expansion result (round key for current round)

Behaviour:
- FSM: IDLE, ROUND, DONE. Registers: fsm, round[3:0], state[127:0], rkey[127:0].
- Reset (async, rst_n=0): fsm=IDLE, round=0, state=0, rkey=0. Outputs: in_ready_o=1, out_valid_o=0, data_o=0, state_o=0, rkey_o=0, rcon_o=0, last_round_o=0.
- IDLE: in_ready_o=1. On in_valid_i&&in_ready_o: state<=data_i^key_i (round-0 AddRoundKey), rkey<=key_i, round<=1, fsm<=ROUND.
- ROUND: in_ready_o=0. Each cycle: state<=round_data_i, rkey<=next_key_i, round<=round+1. rcon_o=RCON[round] (01,02,04,08,10,20,40,80,1B,36 for rounds 1..10). last_round_o=(round==NR). When round==NR: fsm<=DONE, round<=0.
- DONE: out_valid_o=1, data_o=state, held stable until out_ready_i. On out_valid_o&&out_ready_i: fsm<=IDLE. in_ready_o=0 in DONE; a new block cannot be accepted in the same cycle as the output handshake (first accept is possible one cycle later).
- Latency: acceptance in cycle T leads to out_valid_o=1 in cycle T+11. Throughput is one block per 12 cycles minimum.
- Outside ROUND: rcon_o=0 and last_round_o=0.
- data_o=state at all times; it is only meaningful while out_valid_o=1.
- in_valid_i while busy is ignored and not queued; the source holds it until in_ready_o is asserted.
- Reset mid-operation: returns to IDLE immediately and the partial result is discarded; there are no spurious out_valid_o pulses.
- round never exceeds NR. Any illegal fsm encoding returns to IDLE.

Decomposition:
- Package aes_pkg: AES_WIDTH=128, AES_NR=10, RCON[1:10] constant array, fsm state typedef/encodings.
- One natural sub-module: aes_rcon_rom (round -> rcon_o lookup, combinational). The round datapath and key-expansion step stay outside this block.

Test Plan:
- FIPS-197 C.1: bench wires the combinational round and key-expansion models. Plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> data_o=69c4e0d86a7b0430d8cdb78070b4c55a with out_valid_o exactly 11 cycles after acceptance.
- Sequencing: during ROUND, check rcon_o sequence 01,02,04,08,10,20,40,80,1B,36 and last_round_o=1 only in round 10. Datapath input with state a14f3df378e803fc10d5a8df4c632923 in a non-final round -> state register captures the datapath result unchanged.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> out_valid_o stays 1, data_o stable, in_ready_o=0. Release -> IDLE next cycle, in_ready_o=1.
- Busy input: pulse in_valid_i with a different block during ROUND -> ignored; the first ciphertext is correct.
- Reset mid-round: assert rst_n=0 at round 5 -> all outputs return to reset values asynchronously. After release, a new block completes correctly.
- Back-to-back: two blocks with in_valid_i held high -> second accepted one cycle after the first output handshake; both ciphertexts are correct.
